msrv32_dbus_ctrl: RTL and testbench
===================================

MSRV32_DBUS_CTRL -- requirements
Module: msrv32_dbus_ctrl

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 16, meaning: maximum consecutive data-phase wait cycles before the transfer aborts with a bus error.
REQ-002 ms_riscv32_mp_clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 st_req_in  input  1  store request from store unit; held until acked.
REQ-005 st_addr_in / st_data_in / st_mask_in  input  32/32/4  store address, aligned write data, byte-lane mask.
REQ-006 ld_req_in  input  1  load request; held until acked.
REQ-007 ld_addr_in  input  32  load address.
REQ-008 ahb_ready_in / ahb_resp_in  input  1/1  AHB-lite HREADY / HRESP (1 = ERROR).
REQ-009 ahb_haddr_out  output  32  AHB address.
REQ-010 ahb_hwrite_out  output  1  1 = write transfer.
REQ-011 ahb_htrans_out  output  2  00 IDLE, 10 NONSEQ; no other encodings.
REQ-012 ahb_hwdata_out / ahb_wmask_out  output  32/4  write data and byte mask, valid in data phase.
REQ-013 st_ack_out / ld_ack_out  output  1/1  single-cycle accept pulse to the requester.
REQ-014 done_out  output  1  single-cycle pulse on successful transfer completion.
REQ-015 bus_err_out  output  1  single-cycle pulse on HRESP error or timeout.
REQ-016 stall_out  output  1  pipeline stall to core.

Function
REQ-017 FSM states IDLE, ADDR, DATA; one transfer outstanding at most; single transfers only.
REQ-018 IDLE: if st_req_in=1, assert st_ack_out (combinational), latch store addr/data/mask, hwrite=1, go ADDR; else if ld_req_in=1, assert ld_ack_out, latch ld_addr_in, hwrite=0, go ADDR.
REQ-019 Simultaneous st_req_in and ld_req_in in IDLE: store wins; load remains un-acked and is taken on a later IDLE cycle.
REQ-020 Requests arriving in ADDR or DATA are not acked; no ack pulse ever occurs outside IDLE.
REQ-021 ADDR: ahb_htrans_out=10, ahb_haddr_out/ahb_hwrite_out from latched values; ahb_ready_in=1 -> DATA, 0 -> remain in ADDR with outputs held.
REQ-022 DATA: ahb_htrans_out=00; for writes ahb_hwdata_out/ahb_wmask_out = latched data/mask, held stable until completion; for loads both are 0.
REQ-023 DATA with ahb_ready_in=1, ahb_resp_in=0: done_out=1, go IDLE.
REQ-024 DATA with ahb_ready_in=1, ahb_resp_in=1: bus_err_out=1, done_out=0, go IDLE.
REQ-025 Wait counter clears on DATA entry and increments on each DATA cycle with ahb_ready_in=0; when it reaches WAIT_TIMEOUT, bus_err_out=1 and go IDLE the next edge; counter saturates, never wraps.
REQ-026 ahb_htrans_out=00 in IDLE and DATA; minimum transfer latency is 3 cycles (accept, ADDR, DATA), and IDLE re-accepts one cycle after done.
REQ-027 stall_out per REQ-034; done_out and bus_err_out are mutually exclusive.

Reset
REQ-028 On ms_riscv32_mp_rst_n_in=0, immediately (asynchronously): state=IDLE, wait counter=0, all latched registers 0.
REQ-029 Reset values: ahb_haddr_out=0, ahb_hwrite_out=0, ahb_htrans_out=00, ahb_hwdata_out=0, ahb_wmask_out=0, all ack/done/err pulses=0, stall_out=0.
REQ-030 Reset mid-transfer abandons the transfer with no done/err pulse; first accept possible on the first rising edge after deassertion.

Configuration
REQ-031 Macro MSRV32_DBUS_STORE_POST_EN selects posted stores.
REQ-032 Without it: stall_out=1 whenever state is ADDR or DATA.
REQ-033 With it: an in-flight store does not stall the core; loads stall as without it.
REQ-034 With it: stall_out=1 in ADDR/DATA only when the current transfer is a load or st_req_in/ld_req_in is asserted.

Verification
REQ-035 Store addr 0x1000_0004, data 0xABCD_EF01, mask 1111, ready=1 -> st_ack cycle 0; NONSEQ, haddr 0x1000_0004, hwrite=1 cycle 1; hwdata 0xABCD_EF01 and done cycle 2.
REQ-036 Store and load asserted together -> store acked first; load acked the cycle after store done; htrans returns to 00 between transfers.
REQ-037 Load with ready=0 for 3 DATA cycles then 1 -> done exactly 3 cycles late; haddr/hwdata stable throughout; stall=1 all ADDR/DATA cycles.
REQ-038 ready=1 with resp=1 in DATA -> bus_err pulse, no done, FSM back to IDLE.
REQ-039 ready held 0 in DATA, WAIT_TIMEOUT=4 -> bus_err after 4 wait cycles; reset asserted mid-ADDR -> all outputs 0 immediately, no pulses.
REQ-040 With MSRV32_DBUS_STORE_POST_EN, lone store -> stall_out=0 throughout; without it -> stall_out=1 in ADDR and DATA.

Source files
------------

// File: rtl/msrv32_dbus_ctrl.sv
// Single-transfer AHB-lite data bus master for the core's load/store units.
// Define MSRV32_DBUS_STORE_POST_EN to let in-flight stores proceed without stalling the core.
module msrv32_dbus_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        st_req_in,
  input  logic [31:0] st_addr_in,
  input  logic [31:0] st_data_in,
  input  logic [3:0]  st_mask_in,
  input  logic        ld_req_in,
  input  logic [31:0] ld_addr_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] ahb_haddr_out,
  output logic        ahb_hwrite_out,
  output logic [1:0]  ahb_htrans_out,
  output logic [31:0] ahb_hwdata_out,
  output logic [3:0]  ahb_wmask_out,
  output logic        st_ack_out,
  output logic        ld_ack_out,
  output logic        done_out,
  output logic        bus_err_out,
  output logic        stall_out
);

  localparam int unsigned CntW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      mask_q, mask_d;
  logic            write_q, write_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      write_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      write_q    <= write_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    mask_d         = mask_q;
    write_d        = write_q;
    wait_cnt_d     = wait_cnt_q;
    st_ack_out     = 1'b0;
    ld_ack_out     = 1'b0;
    done_out       = 1'b0;
    bus_err_out    = 1'b0;
    ahb_htrans_out = 2'b00;
    ahb_hwdata_out = '0;
    ahb_wmask_out  = '0;
    unique case (state_q)
      StIdle: begin
        // Store has priority; a concurrent load stays pending until a later idle cycle.
        if (st_req_in) begin
          st_ack_out = 1'b1;
          addr_d     = st_addr_in;
          data_d     = st_data_in;
          mask_d     = st_mask_in;
          write_d    = 1'b1;
          state_d    = StAddr;
        end else if (ld_req_in) begin
          ld_ack_out = 1'b1;
          addr_d     = ld_addr_in;
          data_d     = '0;
          mask_d     = '0;
          write_d    = 1'b0;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        ahb_htrans_out = 2'b10;
        if (ahb_ready_in) begin
          state_d    = StData;
          wait_cnt_d = '0;
        end
      end
      StData: begin
        if (write_q) begin
          ahb_hwdata_out = data_q;
          ahb_wmask_out  = mask_q;
        end
        // An exhausted wait budget aborts even if the slave answers this cycle.
        if (wait_cnt_q == CntMax) begin
          bus_err_out = 1'b1;
          state_d     = StIdle;
        end else if (ahb_ready_in) begin
          bus_err_out = ahb_resp_in;
          done_out    = !ahb_resp_in;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ahb_haddr_out  = addr_q;
  assign ahb_hwrite_out = write_q;

`ifdef MSRV32_DBUS_STORE_POST_EN
  assign stall_out = (state_q != StIdle) && (!write_q || st_req_in || ld_req_in);
`else
  assign stall_out = (state_q != StIdle);
`endif

endmodule

// File: tb/tb_msrv32_dbus_ctrl.sv
// Bench for msrv32_dbus_ctrl: directed vector table, corner sequences, and random
// traffic checked against a transaction-level reference model.
module tb_msrv32_dbus_ctrl;

  localparam int unsigned TO = 4;
`ifdef MSRV32_DBUS_STORE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  logic clk, rst_n;
  logic st_req, ld_req, rdy, resp;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [3:0] st_mask;
  logic [31:0] haddr, hwdata;
  logic hwrite, st_ack, ld_ack, done, err, stall;
  logic [1:0] htrans;
  logic [3:0] wmask;

  msrv32_dbus_ctrl #(.WAIT_TIMEOUT(TO)) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .st_req_in             (st_req),
    .st_addr_in            (st_addr),
    .st_data_in            (st_data),
    .st_mask_in            (st_mask),
    .ld_req_in             (ld_req),
    .ld_addr_in            (ld_addr),
    .ahb_ready_in          (rdy),
    .ahb_resp_in           (resp),
    .ahb_haddr_out         (haddr),
    .ahb_hwrite_out        (hwrite),
    .ahb_htrans_out        (htrans),
    .ahb_hwdata_out        (hwdata),
    .ahb_wmask_out         (wmask),
    .st_ack_out            (st_ack),
    .ld_ack_out            (ld_ack),
    .done_out              (done),
    .bus_err_out           (err),
    .stall_out             (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by its attributes.
  logic        m_busy, m_wr, m_in_data;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_mask;
  int          m_waits;
  logic        e_sack, e_lack, e_done, e_err, e_stall;
  logic [1:0]  e_htrans;
  logic [31:0] e_hwdata;
  logic [3:0]  e_mask;

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_in_data = 0; m_addr = 0; m_data = 0; m_mask = 0; m_waits = 0;
  endtask

  task automatic model_eval();
    logic tmo, dph;
    dph      = m_busy && m_in_data;
    tmo      = dph && (m_waits >= int'(TO));
    e_sack   = !m_busy && st_req;
    e_lack   = !m_busy && ld_req && !st_req;
    e_htrans = (m_busy && !m_in_data) ? 2'b10 : 2'b00;
    e_hwdata = (dph && m_wr) ? m_data : 32'h0;
    e_mask   = (dph && m_wr) ? m_mask : 4'h0;
    e_err    = dph && (tmo || (rdy && resp));
    e_done   = dph && !tmo && rdy && !resp;
    e_stall  = m_busy && (POST ? (!m_wr || st_req || ld_req) : 1'b1);
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (st_req) begin
        m_busy = 1; m_wr = 1; m_in_data = 0; m_addr = st_addr; m_data = st_data; m_mask = st_mask;
      end else if (ld_req) begin
        m_busy = 1; m_wr = 0; m_in_data = 0; m_addr = ld_addr; m_data = 0; m_mask = 0;
      end
    end else if (!m_in_data) begin
      if (rdy) begin m_in_data = 1; m_waits = 0; end
    end else if (e_err || e_done) begin
      m_busy = 0;
    end else begin
      m_waits++;
    end
  endtask

  logic        s_sack, s_lack, s_done, s_err, s_stall, s_hwrite;
  logic [1:0]  s_htrans;
  logic [31:0] s_haddr, s_hwdata;
  logic [3:0]  s_mask;

  // One clock cycle: entered and left at a falling edge.
  task automatic cyc(input logic st, input logic ld, input logic r, input logic rs,
                     input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] sm,
                     input logic [31:0] la);
    st_req = st; ld_req = ld; rdy = r; resp = rs;
    st_addr = sa; st_data = sd; st_mask = sm; ld_addr = la;
    #2;
    model_eval();
    s_sack = st_ack; s_lack = ld_ack; s_done = done; s_err = err; s_stall = stall;
    s_htrans = htrans; s_haddr = haddr; s_hwrite = hwrite; s_hwdata = hwdata; s_mask = wmask;
    chk("m_st_ack", 32'(s_sack), 32'(e_sack));
    chk("m_ld_ack", 32'(s_lack), 32'(e_lack));
    chk("m_htrans", 32'(s_htrans), 32'(e_htrans));
    chk("m_hwdata", s_hwdata, e_hwdata);
    chk("m_wmask", 32'(s_mask), 32'(e_mask));
    chk("m_done", 32'(s_done), 32'(e_done));
    chk("m_bus_err", 32'(s_err), 32'(e_err));
    chk("m_stall", 32'(s_stall), 32'(e_stall));
    if (m_busy) begin
      chk("m_haddr", s_haddr, m_addr);
      chk("m_hwrite", 32'(s_hwrite), 32'(m_wr));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_cyc(input logic r);
    cyc(1'b0, 1'b0, r, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_haddr"}, haddr, 32'h0);
    chk({tag, "_hwdata"}, hwdata, 32'h0);
    chk({tag, "_misc"}, {19'h0, hwrite, htrans, wmask, st_ack, ld_ack, done, err, stall}, 32'h0);
  endtask

  typedef struct {
    logic st, ld, rdy, resp;
    logic [31:0] sa, sd;
    logic [3:0] sm;
    logic [31:0] la;
    logic e_sack, e_lack;
    logic [1:0] e_htrans;
    logic e_hw;
    logic [31:0] e_haddr, e_hwdata;
    logic [3:0] e_mask;
    logic e_done, e_err, e_stall_np, e_stall_p, chk_addr;
  } vec_t;

  vec_t vt[14];
  logic st_pend, ld_pend, bias;
  logic [31:0] r_sa, r_sd, r_la;
  logic [3:0] r_sm;

  initial begin
    // st ld rdy rsp  sa sd sm la | sack lack htr hw haddr hwdata mask done err stnp stp chka
    vt[0]  = '{1,0,1,0, 32'h1000_0004, 32'hABCD_EF01, 4'hF, 0,
               1,0,2'b00,0, 0, 0, 4'h0, 0,0, 0,0, 0};
    vt[1]  = '{0,0,1,0, 0, 0, 4'h0, 0,
               0,0,2'b10,1, 32'h1000_0004, 0, 4'h0, 0,0, 1,0, 1};
    vt[2]  = '{0,0,1,0, 0, 0, 4'h0, 0,
               0,0,2'b00,1, 32'h1000_0004, 32'hABCD_EF01, 4'hF, 1,0, 1,0, 1};
    vt[3]  = '{0,0,1,0, 0, 0, 4'h0, 0,
               0,0,2'b00,0, 0, 0, 4'h0, 0,0, 0,0, 0};
    vt[4]  = '{0,1,1,0, 0, 0, 4'h0, 32'h2000_0008,
               0,1,2'b00,0, 0, 0, 4'h0, 0,0, 0,0, 0};
    vt[5]  = '{0,0,1,0, 0, 0, 4'h0, 0,
               0,0,2'b10,0, 32'h2000_0008, 0, 4'h0, 0,0, 1,1, 1};
    vt[6]  = '{0,0,1,1, 0, 0, 4'h0, 0,
               0,0,2'b00,0, 32'h2000_0008, 0, 4'h0, 0,1, 1,1, 1};
    vt[7]  = '{0,0,1,0, 0, 0, 4'h0, 0,
               0,0,2'b00,0, 0, 0, 4'h0, 0,0, 0,0, 0};
    vt[8]  = '{1,1,1,0, 32'h3000_0000, 32'h1122_3344, 4'h3, 32'h4000_0000,
               1,0,2'b00,0, 0, 0, 4'h0, 0,0, 0,0, 0};
    vt[9]  = '{0,1,1,0, 0, 0, 4'h0, 32'h4000_0000,
               0,0,2'b10,1, 32'h3000_0000, 0, 4'h0, 0,0, 1,1, 1};
    vt[10] = '{0,1,1,0, 0, 0, 4'h0, 32'h4000_0000,
               0,0,2'b00,1, 32'h3000_0000, 32'h1122_3344, 4'h3, 1,0, 1,1, 1};
    vt[11] = '{0,1,1,0, 0, 0, 4'h0, 32'h4000_0000,
               0,1,2'b00,0, 0, 0, 4'h0, 0,0, 0,0, 0};
    vt[12] = '{0,0,1,0, 0, 0, 4'h0, 0,
               0,0,2'b10,0, 32'h4000_0000, 0, 4'h0, 0,0, 1,1, 1};
    vt[13] = '{0,0,1,0, 0, 0, 4'h0, 0,
               0,0,2'b00,0, 32'h4000_0000, 0, 4'h0, 1,0, 1,1, 1};

    rst_n = 0; st_req = 0; ld_req = 0; rdy = 0; resp = 0;
    st_addr = 0; st_data = 0; st_mask = 0; ld_addr = 0;
    model_reset();
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].st, vt[i].ld, vt[i].rdy, vt[i].resp, vt[i].sa, vt[i].sd, vt[i].sm, vt[i].la);
      chk($sformatf("v%0d_st_ack", i), 32'(s_sack), 32'(vt[i].e_sack));
      chk($sformatf("v%0d_ld_ack", i), 32'(s_lack), 32'(vt[i].e_lack));
      chk($sformatf("v%0d_htrans", i), 32'(s_htrans), 32'(vt[i].e_htrans));
      chk($sformatf("v%0d_hwdata", i), s_hwdata, vt[i].e_hwdata);
      chk($sformatf("v%0d_wmask", i), 32'(s_mask), 32'(vt[i].e_mask));
      chk($sformatf("v%0d_done", i), 32'(s_done), 32'(vt[i].e_done));
      chk($sformatf("v%0d_err", i), 32'(s_err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_stall", i), 32'(s_stall),
          32'(POST ? vt[i].e_stall_p : vt[i].e_stall_np));
      if (vt[i].chk_addr) begin
        chk($sformatf("v%0d_haddr", i), s_haddr, vt[i].e_haddr);
        chk($sformatf("v%0d_hwrite", i), 32'(s_hwrite), 32'(vt[i].e_hw));
      end
    end

    // Load with three wait states: done arrives on the fourth data cycle.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5000_0010);
    chk("w_accept", 32'(s_lack), 32'h1);
    idle_cyc(1'b1);
    chk("w_addr_stall", 32'(s_stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle_cyc(1'b0);
      chk("w_wait_done", 32'(s_done), 32'h0);
      chk("w_wait_haddr", s_haddr, 32'h5000_0010);
      chk("w_wait_hwdata", s_hwdata, 32'h0);
      chk("w_wait_stall", 32'(s_stall), 32'h1);
    end
    idle_cyc(1'b1);
    chk("w_done", 32'(s_done), 32'h1);
    idle_cyc(1'b1);

    // Lone store that never sees ready in the data phase: timeout after TO waits.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h6000_0000, 32'hDEAD_BEEF, 4'h5, 32'h0);
    idle_cyc(1'b1);
    chk("t_addr_stall", 32'(s_stall), POST ? 32'h0 : 32'h1);
    for (int i = 0; i < int'(TO); i++) begin
      idle_cyc(1'b0);
      chk("t_no_err_yet", 32'(s_err), 32'h0);
      chk("t_data_stall", 32'(s_stall), POST ? 32'h0 : 32'h1);
      chk("t_hwdata_held", s_hwdata, 32'hDEAD_BEEF);
    end
    idle_cyc(1'b0);
    chk("t_timeout_err", 32'(s_err), 32'h1);
    chk("t_timeout_done", 32'(s_done), 32'h0);
    idle_cyc(1'b0);
    chk("t_back_idle", 32'(s_htrans), 32'h0);

    // Reset while in the address phase.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h7000_0000);
    ld_req = 0;
    #2 rst_n = 0;
    #1;
    chk_all_zero("rst_mid");
    model_reset();
    @(negedge clk);
    chk_all_zero("rst_hold");
    rst_n = 1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h1, 4'h1, 32'h0);
    chk("rst_first_accept", 32'(s_sack), 32'h1);
    idle_cyc(1'b1);
    idle_cyc(1'b1);

    // Random traffic; requesters hold requests until the model says they are acked.
    st_pend = 0; ld_pend = 0; bias = 1;
    r_sa = 0; r_sd = 0; r_sm = 0; r_la = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) bias = 1'($urandom_range(0, 1));
      if (!st_pend && $urandom_range(0, 3) == 0) begin
        st_pend = 1; r_sa = $urandom; r_sd = $urandom; r_sm = 4'($urandom_range(0, 15));
      end
      if (!ld_pend && $urandom_range(0, 3) == 0) begin
        ld_pend = 1; r_la = $urandom;
      end
      cyc(st_pend, ld_pend,
          bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
          $urandom_range(0, 7) == 0, r_sa, r_sd, r_sm, r_la);
      if (e_sack) st_pend = 0;
      if (e_lack) ld_pend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
